// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: VGA fetch port, CPU MMIO port and the RAM command/read port.
// The slave modport is the arbiter's view; the master modport is the surrounding SoC's view.
interface vram_arbiter_if #(
   parameter int AW = 15,
   parameter int DW = 12
);
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_gnt;
   logic          vga_rvalid;
   logic [DW-1:0] vga_rdata;

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Two-port arbiter for a single-port synchronous VRAM: VGA has fixed priority, a starvation
// counter lets the CPU win a conflict after STARVE_LIMIT stalls. Two-cycle read latency, pipelined.
module vram_arbiter #(
   parameter int AW           = 15,
   parameter int DW           = 12,
   parameter int STARVE_LIMIT = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   vram_arbiter_if.slave  bus
);
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [7:0]    starve_cnt;
   logic          starve_full;
   logic          vga_gnt;
   logic          cpu_gnt;
   logic          mem_en_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [1:0]    tag_cmd;
   logic [1:0]    tag_rsp;

   // CPU only overrides VGA once it has been stalled STARVE_LIMIT times in a row
   always_comb begin
      starve_full = (starve_cnt == LIMIT);
      vga_gnt     = 1'b0;
      cpu_gnt     = 1'b0;
      if (rst_n) begin
         vga_gnt = bus.vga_req && !(bus.cpu_req && starve_full);
         cpu_gnt = bus.cpu_req && (!bus.vga_req || starve_full);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= 8'd0;
      end else if (cpu_gnt) begin
         starve_cnt <= 8'd0;
      end else if (bus.cpu_req && !starve_full) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end

   // Command stage; address/data hold their last value when no grant is issued
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag_cmd     <= 2'b00;
         tag_rsp     <= 2'b00;
      end else begin
         mem_en_q <= vga_gnt || cpu_gnt;
         mem_we_q <= cpu_gnt && bus.cpu_we;
         if (cpu_gnt) begin
            mem_addr_q <= bus.cpu_addr;
         end else if (vga_gnt) begin
            mem_addr_q <= bus.vga_addr;
         end
         if (cpu_gnt && bus.cpu_we) begin
            mem_wdata_q <= bus.cpu_wdata;
         end
         tag_cmd <= {vga_gnt, cpu_gnt && !bus.cpu_we};
         tag_rsp <= tag_cmd;
      end
   end

   assign bus.vga_gnt    = vga_gnt;
   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.vga_rvalid = tag_rsp[1];
   assign bus.cpu_rvalid = tag_rsp[0];
   assign bus.vga_rdata  = bus.mem_rdata;
   assign bus.cpu_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port synchronous RAM attached.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_vram_arbiter;
   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   check_cnt;

   logic [11:0] vram [0:32767];

   vram_arbiter_if #(.AW(15), .DW(12)) bus ();

   vram_arbiter #(.AW(15), .DW(12), .STARVE_LIMIT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Write takes effect at the edge ending the command cycle; read data appears the cycle after
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= vram[bus.mem_addr];
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic apply_stimulus(input logic vreq, input logic [14:0] vaddr,
                                 input logic creq, input logic cwe,
                                 input logic [14:0] caddr, input logic [11:0] cwdata);
      bus.vga_req   = vreq;
      bus.vga_addr  = vaddr;
      bus.cpu_req   = creq;
      bus.cpu_we    = cwe;
      bus.cpu_addr  = caddr;
      bus.cpu_wdata = cwdata;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      logic        il_vga  [6];
      logic [14:0] il_addr [6];
      logic [11:0] il_data [6];
      logic        exp_cpu;

      pass_cnt  = 0;
      check_cnt = 0;
      for (int a = 0; a < 32768; a++) vram[a] = 12'h000;
      for (int a = 0; a < 4; a++) begin
         vram[a]        = 12'hA00 + 12'(a);
         vram[15'h10+a] = 12'h510 + 12'(a);
      end
      bus.mem_rdata = 12'h000;

      il_vga[0] = 1'b1; il_addr[0] = 15'h0002; il_data[0] = 12'hA02;
      il_vga[1] = 1'b0; il_addr[1] = 15'h0010; il_data[1] = 12'h510;
      il_vga[2] = 1'b1; il_addr[2] = 15'h0003; il_data[2] = 12'hA03;
      il_vga[3] = 1'b0; il_addr[3] = 15'h0011; il_data[3] = 12'h511;
      il_vga[4] = 1'b1; il_addr[4] = 15'h0000; il_data[4] = 12'hA00;
      il_vga[5] = 1'b0; il_addr[5] = 15'h0012; il_data[5] = 12'h512;

      $display("[TB] reset with both requesters active");
      rst_n = 1'b0;
      apply_stimulus(1'b1, 15'h0000, 1'b1, 1'b0, 15'h0000, 12'h000);
      for (int c = 0; c < 3; c++) begin
         sample();
         check_output("rst_vga_gnt", 32'(bus.vga_gnt), 32'd0);
         check_output("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
         check_output("rst_mem_en", 32'(bus.mem_en), 32'd0);
         check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
         check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
         check_output("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
         check_output("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
         check_output("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
         next_cycle();
      end

      $display("[TB] VGA-only burst");
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(i < 4, 15'(i), 1'b0, 1'b0, 15'h0000, 12'h000);
         sample();
         check_output("vga_gnt", 32'(bus.vga_gnt), 32'(i < 4));
         check_output("vga_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
         check_output("vga_mem_en", 32'(bus.mem_en), 32'(i >= 1 && i <= 4));
         if (i >= 1 && i <= 4) check_output("vga_mem_addr", 32'(bus.mem_addr), 32'(i - 1));
         check_output("vga_rvalid", 32'(bus.vga_rvalid), 32'(i >= 2 && i <= 5));
         check_output("vga_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
         if (i >= 2 && i <= 5) check_output("vga_rdata", 32'(bus.vga_rdata), 32'h0A00 + 32'(i - 2));
         next_cycle();
      end

      $display("[TB] CPU write then read-back");
      apply_stimulus(1'b0, 15'h0000, 1'b1, 1'b1, 15'h1234, 12'hFFF);
      sample();
      check_output("wr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      next_cycle();
      apply_stimulus(1'b0, 15'h0000, 1'b1, 1'b0, 15'h1234, 12'h000);
      sample();
      check_output("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      check_output("wr_mem_en", 32'(bus.mem_en), 32'd1);
      check_output("wr_mem_we", 32'(bus.mem_we), 32'd1);
      check_output("wr_mem_addr", 32'(bus.mem_addr), 32'h1234);
      check_output("wr_mem_wdata", 32'(bus.mem_wdata), 32'hFFF);
      next_cycle();
      apply_stimulus(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 12'h000);
      sample();
      check_output("rd_mem_en", 32'(bus.mem_en), 32'd1);
      check_output("rd_mem_we", 32'(bus.mem_we), 32'd0);
      check_output("wr_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      next_cycle();
      sample();
      check_output("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      check_output("rd_cpu_rdata", 32'(bus.cpu_rdata), 32'hFFF);
      check_output("rd_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
      check_output("idle_mem_en", 32'(bus.mem_en), 32'd0);
      next_cycle();
      sample();
      check_output("rd_rvalid_pulse", 32'(bus.cpu_rvalid), 32'd0);
      next_cycle();

      $display("[TB] starvation with both requesters held");
      for (int k = 0; k < 20; k++) begin
         apply_stimulus(k < 18, 15'h0000, k < 18, 1'b0, 15'h0001, 12'h000);
         sample();
         if (k < 18) begin
            check_output("stv_cpu_gnt", 32'(bus.cpu_gnt), 32'(k == 8 || k == 17));
            check_output("stv_vga_gnt", 32'(bus.vga_gnt), 32'(k != 8 && k != 17));
            check_output("stv_cnt", 32'(dut.starve_cnt), (k <= 8) ? 32'(k) : 32'(k - 9));
         end
         if (k >= 2) begin
            exp_cpu = (k - 2 == 8) || (k - 2 == 17);
            check_output("stv_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_cpu));
            check_output("stv_vga_rvalid", 32'(bus.vga_rvalid), 32'(!exp_cpu));
            check_output("stv_rdata", 32'(bus.mem_rdata), exp_cpu ? 32'hA01 : 32'hA00);
         end
         next_cycle();
      end

      $display("[TB] interleaved owners");
      for (int i = 0; i < 8; i++) begin
         if (i < 6) apply_stimulus(il_vga[i], il_addr[i], !il_vga[i], 1'b0, il_addr[i], 12'h000);
         else       apply_stimulus(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 12'h000);
         sample();
         if (i < 6) begin
            check_output("il_vga_gnt", 32'(bus.vga_gnt), 32'(il_vga[i]));
            check_output("il_cpu_gnt", 32'(bus.cpu_gnt), 32'(!il_vga[i]));
         end
         if (i >= 2) begin
            check_output("il_vga_rvalid", 32'(bus.vga_rvalid), 32'(il_vga[i-2]));
            check_output("il_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!il_vga[i-2]));
            if (il_vga[i-2]) check_output("il_vga_rdata", 32'(bus.vga_rdata), 32'(il_data[i-2]));
            else             check_output("il_cpu_rdata", 32'(bus.cpu_rdata), 32'(il_data[i-2]));
         end else begin
            check_output("il_pre_rvalid", 32'({bus.vga_rvalid, bus.cpu_rvalid}), 32'd0);
         end
         next_cycle();
      end

      $display("[TB] reset during an in-flight VGA read");
      apply_stimulus(1'b1, 15'h0001, 1'b0, 1'b0, 15'h0000, 12'h000);
      sample();
      check_output("mf_vga_gnt", 32'(bus.vga_gnt), 32'd1);
      next_cycle();
      rst_n = 1'b0;
      sample();
      check_output("mf_gnt_in_rst", 32'(bus.vga_gnt), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      apply_stimulus(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 12'h000);
      sample();
      check_output("mf_no_rvalid", 32'(bus.vga_rvalid), 32'd0);
      check_output("mf_mem_en", 32'(bus.mem_en), 32'd0);
      next_cycle();
      apply_stimulus(1'b1, 15'h0003, 1'b0, 1'b0, 15'h0000, 12'h000);
      sample();
      check_output("mf_post_gnt", 32'(bus.vga_gnt), 32'd1);
      check_output("mf_post_idle", 32'(bus.vga_rvalid), 32'd0);
      next_cycle();
      apply_stimulus(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 12'h000);
      sample();
      check_output("mf_post_lat1", 32'(bus.vga_rvalid), 32'd0);
      next_cycle();
      sample();
      check_output("mf_post_rvalid", 32'(bus.vga_rvalid), 32'd1);
      check_output("mf_post_rdata", 32'(bus.vga_rdata), 32'hA03);
      next_cycle();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
